// File: rtl/axi4_addr_chan_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_addr_chan_arb_mux_if
// Brief    : Bundle of master address channels, arbiter handshake, slave-side
//            address slice and open-transaction status for one slave port.
// Revision : 1.0  initial release
// ============================================================================
interface axi4_addr_chan_arb_mux_if #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int OPEN_CNT_WIDTH = 4
);
    logic [NUM_MASTERS-1:0]             mst_valid;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]  mst_addr;
    logic [NUM_MASTERS*ID_WIDTH-1:0]    mst_id;
    logic [NUM_MASTERS*LEN_WIDTH-1:0]   mst_len;
    logic [NUM_MASTERS-1:0]             mst_ready;

    logic [NUM_MASTERS-1:0]             requestor;
    logic                               arbEnable;
    logic [NUM_MASTERS-1:0]             grant;
    logic [MASTER_WIDTH-1:0]            grantEnc;
    logic                               grantValid;

    logic                               slv_valid;
    logic [ADDR_WIDTH-1:0]              slv_addr;
    logic [ID_WIDTH+MASTER_WIDTH-1:0]   slv_id;
    logic [LEN_WIDTH-1:0]               slv_len;
    logic                               slv_ready;

    logic                               trans_done;
    logic [OPEN_CNT_WIDTH-1:0]          open_cnt;
    logic                               limit_hit;

    // The mux block itself
    modport slave (
        input  mst_valid, mst_addr, mst_id, mst_len,
        input  grant, grantEnc, grantValid,
        input  slv_ready, trans_done,
        output mst_ready, requestor, arbEnable,
        output slv_valid, slv_addr, slv_id, slv_len,
        output open_cnt, limit_hit
    );

    // Masters, arbiter and downstream slave seen as one environment
    modport master (
        output mst_valid, mst_addr, mst_id, mst_len,
        output grant, grantEnc, grantValid,
        output slv_ready, trans_done,
        input  mst_ready, requestor, arbEnable,
        input  slv_valid, slv_addr, slv_id, slv_len,
        input  open_cnt, limit_hit
    );
endinterface
`default_nettype wire

// File: rtl/axi4_addr_chan_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : axi4_addr_chan_arb_mux
// Brief    : Address-channel front end of a crossbar slave port: arbiter
//            request/grant glue, granted-beat mux, one-entry output slice and
//            open-transaction limiter.
// Revision : 1.0  initial release
// ============================================================================
module axi4_addr_chan_arb_mux #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_WIDTH   = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int OPEN_TRANS_MAX = 8,
    parameter int OPEN_CNT_WIDTH = 4
) (
    input  wire                       sysClk,
    input  wire                       sysReset,
    axi4_addr_chan_arb_mux_if.slave   bus
);
    localparam int SUM_W = OPEN_CNT_WIDTH + 1;
    localparam logic [SUM_W-1:0] c_open_max = SUM_W'(OPEN_TRANS_MAX);

    logic                              r_run;
    logic                              r_slv_valid;
    logic [ADDR_WIDTH-1:0]             r_slv_addr;
    logic [ID_WIDTH+MASTER_WIDTH-1:0]  r_slv_id;
    logic [LEN_WIDTH-1:0]              r_slv_len;
    logic [OPEN_CNT_WIDTH-1:0]         r_open_cnt;

    logic                              w_slice_free;
    logic [SUM_W-1:0]                  w_pending;
    logic                              w_limit_hit;
    logic                              w_granted_live;
    logic                              w_capture;
    logic                              w_slv_hs;
    logic [ADDR_WIDTH-1:0]             w_sel_addr;
    logic [ID_WIDTH-1:0]               w_sel_id;
    logic [LEN_WIDTH-1:0]              w_sel_len;
    logic [OPEN_CNT_WIDTH-1:0]         w_open_cnt_nxt;

    assign w_slice_free   = ~r_slv_valid | bus.slv_ready;
    // A beat parked in the slice already holds a slot against the limit
    assign w_pending      = {1'b0, r_open_cnt} + SUM_W'(r_slv_valid);
    assign w_limit_hit    = (w_pending >= c_open_max);
    assign w_granted_live = |(bus.grant & bus.mst_valid);
    assign w_slv_hs       = r_slv_valid & bus.slv_ready;

    // r_run keeps the first cycle after reset release free of handshakes
    assign w_capture = r_run & bus.grantValid & w_slice_free & ~w_limit_hit
                     & w_granted_live;

    assign bus.mst_ready = w_capture ? bus.grant : '0;
    assign bus.arbEnable = w_capture;
    assign bus.requestor = bus.mst_valid & {NUM_MASTERS{~w_limit_hit}};
    assign bus.limit_hit = w_limit_hit;
    assign bus.slv_valid = r_slv_valid;
    assign bus.slv_addr  = r_slv_addr;
    assign bus.slv_id    = r_slv_id;
    assign bus.slv_len   = r_slv_len;
    assign bus.open_cnt  = r_open_cnt;

    always_comb begin
        w_sel_addr = '0;
        w_sel_id   = '0;
        w_sel_len  = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (bus.grantEnc == MASTER_WIDTH'(m)) begin
                w_sel_addr = bus.mst_addr[m*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_id   = bus.mst_id[m*ID_WIDTH +: ID_WIDTH];
                w_sel_len  = bus.mst_len[m*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    always_comb begin
        w_open_cnt_nxt = r_open_cnt;
        if (w_slv_hs && !bus.trans_done) begin
            w_open_cnt_nxt = r_open_cnt + OPEN_CNT_WIDTH'(1);
        end else if (!w_slv_hs && bus.trans_done && (r_open_cnt != '0)) begin
            w_open_cnt_nxt = r_open_cnt - OPEN_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_slv_valid <= 1'b0;
            r_slv_addr  <= '0;
            r_slv_id    <= '0;
            r_slv_len   <= '0;
        end else if (w_capture) begin
            r_slv_valid <= 1'b1;
            r_slv_addr  <= w_sel_addr;
            r_slv_id    <= {bus.grantEnc, w_sel_id};
            r_slv_len   <= w_sel_len;
        end else if (w_slv_hs) begin
            r_slv_valid <= 1'b0;
        end
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            r_open_cnt <= '0;
        end else begin
            r_open_cnt <= w_open_cnt_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi4_addr_chan_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_addr_chan_arb_mux
// Brief    : Directed self-checking bench with a round-robin arbiter model;
//            a second instance with a limit of 2 exercises the limiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_addr_chan_arb_mux;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi4_addr_chan_arb_mux_if bus_a ();
    axi4_addr_chan_arb_mux_if bus_b ();

    axi4_addr_chan_arb_mux #(.OPEN_TRANS_MAX(8)) dut_a (.sysClk(clk), .sysReset(rst), .bus(bus_a.slave));
    axi4_addr_chan_arb_mux #(.OPEN_TRANS_MAX(2)) dut_b (.sysClk(clk), .sysReset(rst), .bus(bus_b.slave));

    logic [3:0]   mst_valid;
    logic [127:0] mst_addr;
    logic [15:0]  mst_id;
    logic [31:0]  mst_len;
    logic         slv_ready, trans_done;
    logic         arb_auto, sel_b;
    logic [3:0]   man_grant;
    logic [1:0]   man_enc;
    logic         man_gv;

    logic [3:0]   arb_grant;
    logic [1:0]   arb_enc, arb_last, arb_cand, arb_nxt_idx;
    logic         arb_gv, arb_nxt_found;
    wire  [3:0]   arb_req = sel_b ? bus_b.requestor : bus_a.requestor;
    wire          arb_en  = sel_b ? bus_b.arbEnable : bus_a.arbEnable;

    assign bus_a.mst_valid  = mst_valid;   assign bus_b.mst_valid  = mst_valid;
    assign bus_a.mst_addr   = mst_addr;    assign bus_b.mst_addr   = mst_addr;
    assign bus_a.mst_id     = mst_id;      assign bus_b.mst_id     = mst_id;
    assign bus_a.mst_len    = mst_len;     assign bus_b.mst_len    = mst_len;
    assign bus_a.slv_ready  = slv_ready;   assign bus_b.slv_ready  = slv_ready;
    assign bus_a.trans_done = trans_done;  assign bus_b.trans_done = trans_done;
    assign bus_a.grant      = arb_auto ? arb_grant : man_grant;
    assign bus_b.grant      = arb_auto ? arb_grant : man_grant;
    assign bus_a.grantEnc   = arb_auto ? arb_enc : man_enc;
    assign bus_b.grantEnc   = arb_auto ? arb_enc : man_enc;
    assign bus_a.grantValid = arb_auto ? arb_gv : man_gv;
    assign bus_b.grantValid = arb_auto ? arb_gv : man_gv;

    // Round-robin arbiter model: re-grants on arbEnable, when idle, or when the held grant went stale
    always_comb begin
        arb_cand = '0;
        arb_nxt_idx = '0;
        arb_nxt_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            arb_cand = arb_last + 2'(k);
            if (!arb_nxt_found && arb_req[arb_cand]) begin
                arb_nxt_found = 1'b1;
                arb_nxt_idx = arb_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_gv <= 1'b0; arb_grant <= '0; arb_enc <= '0; arb_last <= 2'd3;
        end else if (!arb_gv || arb_en || ((arb_grant & arb_req) == 4'b0000)) begin
            arb_gv    <= arb_nxt_found;
            arb_grant <= arb_nxt_found ? (4'b0001 << arb_nxt_idx) : 4'b0000;
            arb_enc   <= arb_nxt_idx;
            if (arb_nxt_found) arb_last <= arb_nxt_idx;
        end
    end

    int stale_cnt = 0;
    always_ff @(posedge clk) begin
        if (!rst && bus_a.grantValid && ((bus_a.grant & bus_a.mst_valid) == 4'b0000))
            stale_cnt <= stale_cnt + 1;
    end

    int vectors = 0;
    int errs = 0;

    task automatic pos1();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        mst_valid = '0; mst_addr = '0; mst_id = '0; mst_len = '0;
        slv_ready = 1'b0; trans_done = 1'b0;
        arb_auto = 1'b1; sel_b = 1'b0; man_grant = '0; man_enc = '0; man_gv = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus_a.slv_valid !== 1'b0) begin errs++; $display("FAIL rst_slv_valid: got %b want 0", bus_a.slv_valid); end
        vectors++; if (bus_a.slv_addr !== 32'h0) begin errs++; $display("FAIL rst_slv_addr: got %h want 0", bus_a.slv_addr); end
        vectors++; if (bus_a.slv_id !== 6'h0) begin errs++; $display("FAIL rst_slv_id: got %h want 0", bus_a.slv_id); end
        vectors++; if (bus_a.slv_len !== 8'h0) begin errs++; $display("FAIL rst_slv_len: got %h want 0", bus_a.slv_len); end
        vectors++; if (bus_a.open_cnt !== 4'h0) begin errs++; $display("FAIL rst_open_cnt: got %0d want 0", bus_a.open_cnt); end
        vectors++; if (bus_a.mst_ready !== 4'b0) begin errs++; $display("FAIL rst_mst_ready: got %b want 0000", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b0) begin errs++; $display("FAIL rst_arbEnable: got %b want 0", bus_a.arbEnable); end
        vectors++; if (bus_a.requestor !== 4'b0) begin errs++; $display("FAIL rst_requestor: got %b want 0000", bus_a.requestor); end
        vectors++; if (bus_a.limit_hit !== 1'b0) begin errs++; $display("FAIL rst_limit_hit: got %b want 0", bus_a.limit_hit); end
        pos1();
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        mst_valid = 4'b0010; mst_addr[32 +: 32] = 32'h1000_0040; mst_id[4 +: 4] = 4'h3; mst_len[8 +: 8] = 8'd7;
        slv_ready = 1'b1;
        #1;
        vectors++; if (bus_a.requestor !== 4'b0010) begin errs++; $display("FAIL single_req: got %b want 0010", bus_a.requestor); end
        vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL single_no_grant_ready: got %b want 0000", bus_a.mst_ready); end
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b0010) begin errs++; $display("FAIL single_ready: got %b want 0010", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b1) begin errs++; $display("FAIL single_arben: got %b want 1", bus_a.arbEnable); end
        pos1();
        mst_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (bus_a.slv_valid !== 1'b1) begin errs++; $display("FAIL single_slv_valid: got %b want 1", bus_a.slv_valid); end
        vectors++; if (bus_a.slv_addr !== 32'h1000_0040) begin errs++; $display("FAIL single_addr: got %h want 10000040", bus_a.slv_addr); end
        vectors++; if (bus_a.slv_id !== 6'h13) begin errs++; $display("FAIL single_id: got %h want 13", bus_a.slv_id); end
        vectors++; if (bus_a.slv_len !== 8'd7) begin errs++; $display("FAIL single_len: got %0d want 7", bus_a.slv_len); end
        vectors++; if (bus_a.arbEnable !== 1'b0) begin errs++; $display("FAIL single_arben_low: got %b want 0", bus_a.arbEnable); end
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd1) begin errs++; $display("FAIL single_open: got %0d want 1", bus_a.open_cnt); end
        vectors++; if (bus_a.slv_valid !== 1'b0) begin errs++; $display("FAIL single_drained: got %b want 0", bus_a.slv_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_m, prev_m;
        apply_reset();
        mst_addr[0 +: 32] = 32'hA000_0000; mst_id[0 +: 4] = 4'h5; mst_len[0 +: 8] = 8'd1;
        mst_addr[64 +: 32] = 32'hA000_0200; mst_id[8 +: 4] = 4'h9; mst_len[16 +: 8] = 8'd2;
        mst_valid = 4'b0101; slv_ready = 1'b1;
        prev_m = 2'd0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_m = (i % 2 == 0) ? 2'd0 : 2'd2;
            vectors++; if (bus_a.mst_ready !== (4'b0001 << exp_m)) begin errs++; $display("FAIL b2b_ready[%0d]: got %b want master %0d", i, bus_a.mst_ready, exp_m); end
            vectors++; if (bus_a.arbEnable !== 1'b1) begin errs++; $display("FAIL b2b_arben[%0d]: got %b want 1", i, bus_a.arbEnable); end
            if (i > 0) begin
                vectors++; if (bus_a.slv_id[5:4] !== prev_m) begin errs++; $display("FAIL b2b_id_master[%0d]: got %0d want %0d", i, bus_a.slv_id[5:4], prev_m); end
            end
            prev_m = exp_m;
            if (i < 3) begin
                @(negedge clk);
            end else begin
                pos1();
                mst_valid = 4'b0000;
                @(negedge clk);
            end
        end
        vectors++; if (bus_a.slv_id !== 6'h29) begin errs++; $display("FAIL b2b_last_id: got %h want 29", bus_a.slv_id); end
        vectors++; if (bus_a.slv_addr !== 32'hA000_0200) begin errs++; $display("FAIL b2b_last_addr: got %h want a0000200", bus_a.slv_addr); end
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd4) begin errs++; $display("FAIL b2b_open: got %0d want 4", bus_a.open_cnt); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mst_addr[96 +: 32] = 32'h3000_0000; mst_id[12 +: 4] = 4'hC; mst_len[24 +: 8] = 8'h0F;
        mst_valid = 4'b1000; slv_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b1000) begin errs++; $display("FAIL bp_first_ready: got %b want 1000", bus_a.mst_ready); end
        pos1();
        mst_addr[96 +: 32] = 32'h3000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (bus_a.slv_addr !== 32'h3000_0000) begin errs++; $display("FAIL bp_hold_addr[%0d]: got %h want 30000000", i, bus_a.slv_addr); end
            vectors++; if (bus_a.slv_valid !== 1'b1) begin errs++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus_a.slv_valid); end
            vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL bp_no_ready[%0d]: got %b want 0000", i, bus_a.mst_ready); end
            vectors++; if (bus_a.requestor !== 4'b1000) begin errs++; $display("FAIL bp_req_held[%0d]: got %b want 1000", i, bus_a.requestor); end
        end
        slv_ready = 1'b1;
        #1;
        vectors++; if (bus_a.mst_ready !== 4'b1000) begin errs++; $display("FAIL bp_pass_ready: got %b want 1000", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b1) begin errs++; $display("FAIL bp_pass_arben: got %b want 1", bus_a.arbEnable); end
        pos1();
        mst_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (bus_a.slv_addr !== 32'h3000_0100) begin errs++; $display("FAIL bp_pass_addr: got %h want 30000100", bus_a.slv_addr); end
        vectors++; if (bus_a.slv_valid !== 1'b1) begin errs++; $display("FAIL bp_pass_valid: got %b want 1", bus_a.slv_valid); end
        vectors++; if (bus_a.open_cnt !== 4'd1) begin errs++; $display("FAIL bp_open: got %0d want 1", bus_a.open_cnt); end
    endtask

    task automatic test_limit();
        apply_reset();
        sel_b = 1'b1;
        mst_addr[0 +: 32] = 32'h4000_0000; mst_id[0 +: 4] = 4'h1; mst_len[0 +: 8] = 8'd3;
        mst_valid = 4'b0001; slv_ready = 1'b1;
        @(negedge clk);
        vectors++; if (bus_b.mst_ready !== 4'b0001) begin errs++; $display("FAIL lim_beat1: got %b want 0001", bus_b.mst_ready); end
        pos1();
        mst_addr[0 +: 32] = 32'h4000_0010;
        @(negedge clk);
        vectors++; if (bus_b.mst_ready !== 4'b0001) begin errs++; $display("FAIL lim_beat2: got %b want 0001", bus_b.mst_ready); end
        vectors++; if (bus_b.limit_hit !== 1'b0) begin errs++; $display("FAIL lim_not_yet: got %b want 0", bus_b.limit_hit); end
        pos1();
        mst_addr[0 +: 32] = 32'h4000_0020;
        @(negedge clk);
        vectors++; if (bus_b.limit_hit !== 1'b1) begin errs++; $display("FAIL lim_hit_slice: got %b want 1", bus_b.limit_hit); end
        vectors++; if (bus_b.requestor !== 4'b0000) begin errs++; $display("FAIL lim_req_masked: got %b want 0000", bus_b.requestor); end
        vectors++; if (bus_b.mst_ready !== 4'b0000) begin errs++; $display("FAIL lim_blocked: got %b want 0000", bus_b.mst_ready); end
        vectors++; if (bus_b.open_cnt !== 4'd1) begin errs++; $display("FAIL lim_open1: got %0d want 1", bus_b.open_cnt); end
        @(negedge clk);
        vectors++; if (bus_b.open_cnt !== 4'd2) begin errs++; $display("FAIL lim_open2: got %0d want 2", bus_b.open_cnt); end
        vectors++; if (bus_b.limit_hit !== 1'b1) begin errs++; $display("FAIL lim_hit_cnt: got %b want 1", bus_b.limit_hit); end
        vectors++; if (bus_b.slv_valid !== 1'b0) begin errs++; $display("FAIL lim_slice_empty: got %b want 0", bus_b.slv_valid); end
        trans_done = 1'b1;
        pos1();
        trans_done = 1'b0;
        @(negedge clk);
        vectors++; if (bus_b.open_cnt !== 4'd1) begin errs++; $display("FAIL lim_done_dec: got %0d want 1", bus_b.open_cnt); end
        vectors++; if (bus_b.limit_hit !== 1'b0) begin errs++; $display("FAIL lim_cleared: got %b want 0", bus_b.limit_hit); end
        vectors++; if (bus_b.requestor !== 4'b0001) begin errs++; $display("FAIL lim_req_back: got %b want 0001", bus_b.requestor); end
        @(negedge clk);
        vectors++; if (bus_b.mst_ready !== 4'b0001) begin errs++; $display("FAIL lim_beat3: got %b want 0001", bus_b.mst_ready); end
        vectors++; if (bus_b.arbEnable !== 1'b1) begin errs++; $display("FAIL lim_beat3_arben: got %b want 1", bus_b.arbEnable); end
        pos1();
        mst_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (bus_b.slv_addr !== 32'h4000_0020) begin errs++; $display("FAIL lim_beat3_addr: got %h want 40000020", bus_b.slv_addr); end
        vectors++; if (bus_b.limit_hit !== 1'b1) begin errs++; $display("FAIL lim_rehit: got %b want 1", bus_b.limit_hit); end
        sel_b = 1'b0;
    endtask

    task automatic test_open_counter();
        apply_reset();
        mst_addr[0 +: 32] = 32'h5000_0000; mst_valid = 4'b0001; slv_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b0001) begin errs++; $display("FAIL cnt_cap1: got %b want 0001", bus_a.mst_ready); end
        pos1();
        mst_addr[0 +: 32] = 32'h5000_0004;
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL cnt_full: got %b want 0000", bus_a.mst_ready); end
        slv_ready = 1'b1;
        #1;
        vectors++; if (bus_a.mst_ready !== 4'b0001) begin errs++; $display("FAIL cnt_passthru: got %b want 0001", bus_a.mst_ready); end
        pos1();
        mst_valid = 4'b0000; trans_done = 1'b1;
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd1) begin errs++; $display("FAIL cnt_pre: got %0d want 1", bus_a.open_cnt); end
        vectors++; if (bus_a.slv_addr !== 32'h5000_0004) begin errs++; $display("FAIL cnt_addr2: got %h want 50000004", bus_a.slv_addr); end
        pos1();
        trans_done = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd1) begin errs++; $display("FAIL cnt_inc_dec: got %0d want 1", bus_a.open_cnt); end
        vectors++; if (bus_a.slv_valid !== 1'b0) begin errs++; $display("FAIL cnt_drained: got %b want 0", bus_a.slv_valid); end
        trans_done = 1'b1;
        pos1();
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd0) begin errs++; $display("FAIL cnt_to_zero: got %0d want 0", bus_a.open_cnt); end
        pos1();
        trans_done = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd0) begin errs++; $display("FAIL cnt_no_wrap: got %0d want 0", bus_a.open_cnt); end
    endtask

    task automatic test_stale_grant();
        int s0;
        apply_reset();
        arb_auto = 1'b0;
        mst_addr[64 +: 32] = 32'h6000_0000; mst_id[8 +: 4] = 4'h7;
        mst_valid = 4'b0100; slv_ready = 1'b1;
        man_grant = 4'b0001; man_enc = 2'd0; man_gv = 1'b1;
        s0 = stale_cnt;
        #1;
        vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL stale_ready: got %b want 0000", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b0) begin errs++; $display("FAIL stale_arben: got %b want 0", bus_a.arbEnable); end
        @(negedge clk);
        vectors++; if (bus_a.slv_valid !== 1'b0) begin errs++; $display("FAIL stale_no_beat: got %b want 0", bus_a.slv_valid); end
        vectors++; if (stale_cnt - s0 !== 1) begin errs++; $display("FAIL stale_flagged: got %0d want 1", stale_cnt - s0); end
        man_grant = 4'b0100; man_enc = 2'd2;
        #1;
        vectors++; if (bus_a.mst_ready !== 4'b0100) begin errs++; $display("FAIL stale_fixed_ready: got %b want 0100", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b1) begin errs++; $display("FAIL stale_fixed_arben: got %b want 1", bus_a.arbEnable); end
        pos1();
        man_gv = 1'b0; mst_valid = 4'b0000;
        @(negedge clk);
        vectors++; if (bus_a.slv_id !== 6'h27) begin errs++; $display("FAIL stale_fixed_id: got %h want 27", bus_a.slv_id); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mst_addr[0 +: 32] = 32'h7000_0000; mst_valid = 4'b0001; slv_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        pos1();
        slv_ready = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.open_cnt !== 4'd3) begin errs++; $display("FAIL rmid_open_pre: got %0d want 3", bus_a.open_cnt); end
        vectors++; if (bus_a.slv_valid !== 1'b1) begin errs++; $display("FAIL rmid_valid_pre: got %b want 1", bus_a.slv_valid); end
        arb_auto = 1'b0; man_grant = 4'b0001; man_enc = 2'd0; man_gv = 1'b1;
        #1 rst = 1'b1;
        #1;
        vectors++; if (bus_a.slv_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid: got %b want 0", bus_a.slv_valid); end
        vectors++; if (bus_a.open_cnt !== 4'd0) begin errs++; $display("FAIL rmid_open: got %0d want 0", bus_a.open_cnt); end
        vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL rmid_ready: got %b want 0000", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b0) begin errs++; $display("FAIL rmid_arben: got %b want 0", bus_a.arbEnable); end
        pos1();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b0000) begin errs++; $display("FAIL rmid_first_cycle: got %b want 0000", bus_a.mst_ready); end
        vectors++; if (bus_a.arbEnable !== 1'b0) begin errs++; $display("FAIL rmid_first_arben: got %b want 0", bus_a.arbEnable); end
        @(negedge clk);
        vectors++; if (bus_a.mst_ready !== 4'b0001) begin errs++; $display("FAIL rmid_resume: got %b want 0001", bus_a.mst_ready); end
        pos1();
        mst_valid = 4'b0000; man_gv = 1'b0;
        @(negedge clk);
        vectors++; if (bus_a.slv_valid !== 1'b1) begin errs++; $display("FAIL rmid_resume_valid: got %b want 1", bus_a.slv_valid); end
        vectors++; if (bus_a.open_cnt !== 4'd0) begin errs++; $display("FAIL rmid_resume_open: got %0d want 0", bus_a.open_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_limit();
        test_open_counter();
        test_stale_grant();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
`default_nettype wire
